// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// started by a start pulse and finished with a one-cycle done pulse.
module bcd_serial_adder #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, next_state;

    logic [4*N_DIGITS-1:0] a_r, b_r, sum_r;
    logic                  sub_r, carry, cout_r, err_r, done_r;
    logic [IDX_W-1:0]      idx;

    logic [3:0] a_dig, b_dig, beff, res_dig;
    logic [4:0] s;
    logic       c_next, dig_bad;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (idx == LAST_IDX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Subtraction uses 9's complement of B with the initial carry inverted from borrow-in.
    always_comb begin
        a_dig   = a_r[idx*4 +: 4];
        b_dig   = b_r[idx*4 +: 4];
        beff    = sub_r ? (4'd9 - b_dig) : b_dig;
        s       = {1'b0, a_dig} + {1'b0, beff} + {4'b0000, carry};
        c_next  = (s > 5'd9);
        res_dig = c_next ? 4'(s + 5'd6) : s[3:0];
        dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                        sum_r <= '0;
                        err_r <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r[idx*4 +: 4] <= res_dig;
                    carry             <= c_next;
                    if (dig_bad) err_r <= 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_r <= c_next;
                        done_r <= 1'b1;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign err  = err_r;

endmodule
